univ_shift_reg: RTL

- Parametrised universal register, next generation of the team's 4-bit load/hold register.
- Generalised to WIDTH bits.
- Adds shift left/right with serial inputs, rotate left/right, synchronous clear and a global clock enable.
- Used as the general storage/serialiser element in datapath exercises and as a building block for serial transmit/receive logic.

---
 rtl/usr_pkg.sv | 18 +
 rtl/usr_bit_cell.sv | 46 ++++
 rtl/univ_shift_reg.sv | 86 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types and limits for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } usr_mode_t;

  localparam int unsigned USR_MIN_WIDTH = 2;
  localparam int unsigned USR_MAX_WIDTH = 64;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit slice of the universal shift register: mode-indexed source select
// feeding a flop with asynchronous active-low reset to a per-bit value.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RstVal = 1'b0
) (
  input  logic      clk,
  input  logic      rstb,
  input  usr_mode_t mode_i,
  input  logic      shr_i,
  input  logic      shl_i,
  input  logic      ror_i,
  input  logic      rol_i,
  input  logic      load_i,
  output logic      q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (mode_i)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = shr_i;
      MODE_SHL:  q_d = shl_i;
      MODE_LOAD: q_d = load_i;
      MODE_ROR:  q_d = ror_i;
      MODE_ROL:  q_d = rol_i;
      MODE_CLR:  q_d = 1'b0;
      MODE_RSVD: q_d = q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/shift/rotate/load/clear with clock enable.
// Define USR_PARITY_EN to add the registered even-parity output par.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sir,
  input  logic             sil,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] A,
  output logic             sor,
`ifdef USR_PARITY_EN
  output logic             par,
`endif
  output logic             sol
);

  if (WIDTH < USR_MIN_WIDTH || WIDTH > USR_MAX_WIDTH) begin : g_bad_width
    $error("univ_shift_reg: WIDTH must be within 2..64");
  end

  // Disabled clock enable is folded into a HOLD so the cells see one select.
  usr_mode_t mode_eff;
  assign mode_eff = en ? usr_mode_t'(mode) : MODE_HOLD;

  logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v;
  assign shr_v = {sir, A[WIDTH-1:1]};
  assign ror_v = {A[0], A[WIDTH-1:1]};
  assign shl_v = {A[WIDTH-2:0], sil};
  assign rol_v = {A[WIDTH-2:0], A[WIDTH-1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell #(
      .RstVal (RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rstb   (rstb),
      .mode_i (mode_eff),
      .shr_i  (shr_v[i]),
      .shl_i  (shl_v[i]),
      .ror_i  (ror_v[i]),
      .rol_i  (rol_v[i]),
      .load_i (I[i]),
      .q_o    (A[i])
    );
  end

  assign sor = A[0];
  assign sol = A[WIDTH-1];

`ifdef USR_PARITY_EN
  logic par_q, par_d;

  // Next parity from the current parity terms: a shift swaps one bit for the serial-in.
  always_comb begin
    par_d = par_q;
    case (mode_eff)
      MODE_HOLD, MODE_RSVD, MODE_ROR, MODE_ROL: par_d = ^A;
      MODE_SHR:  par_d = ^A ^ A[0] ^ sir;
      MODE_SHL:  par_d = ^A ^ A[WIDTH-1] ^ sil;
      MODE_LOAD: par_d = ^I;
      MODE_CLR:  par_d = 1'b0;
      default:   par_d = par_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      par_q <= ^RST_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;
`endif

  mode_known_a: assert property (@(posedge clk) disable iff (!rstb) en |-> !$isunknown(mode));

endmodule
